// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module : fetch_pkg
// Desc   : Shared constants and the buffered fetch entry type.
// Rev    : 1.0
// ============================================================================
package fetch_pkg;

    localparam int                 INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
        logic               filled;
    } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/fetch_buffer.sv
`default_nettype none
// ============================================================================
// Module : fetch_buffer
// Desc   : Ordered circular queue of fetched PC/instruction entries.
// Rev    : 1.0
// ============================================================================
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_flush,
    input  logic                    i_alloc,
    input  logic [31:0]             i_alloc_pc,
    input  logic                    i_fill,
    input  logic [INSTR_W-1:0]      i_fill_instr,
    input  logic                    i_pop,
    output logic                    o_head_valid,
    output fetch_entry_t            o_head,
    output logic [$clog2(DEPTH):0]  o_alloc_cnt,
    output logic [$clog2(DEPTH):0]  o_unfilled_cnt
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [AW:0] c_ptr_one  = {{AW{1'b0}}, 1'b1};

    // Pointers carry one wrap bit so full and empty are distinguishable.
    logic [AW:0]  r_head;
    logic [AW:0]  r_tail;
    logic [AW:0]  r_fill;
    fetch_entry_t r_mem [DEPTH];

    assign o_alloc_cnt    = r_tail - r_head;
    assign o_unfilled_cnt = r_tail - r_fill;
    assign o_head         = r_mem[r_head[AW-1:0]];
    assign o_head_valid   = (r_head != r_tail) && o_head.filled;

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_head <= '0;
            r_tail <= '0;
            r_fill <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '{pc: '0, instr: NOP_INSTR, filled: 1'b0};
            end
        end else begin
            if (i_alloc) begin
                r_mem[r_tail[AW-1:0]] <= '{pc: i_alloc_pc, instr: NOP_INSTR, filled: 1'b0};
                r_tail                <= r_tail + c_ptr_one;
            end
            // Fill always lands on an older slot than the one being allocated.
            if (i_fill) begin
                r_mem[r_fill[AW-1:0]].instr  <= i_fill_instr;
                r_mem[r_fill[AW-1:0]].filled <= 1'b1;
                r_fill                       <= r_fill + c_ptr_one;
            end
            if (i_pop) begin
                r_head <= r_head + c_ptr_one;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : fetch_stage
// Desc   : PC owner, in-order instruction fetch issue and redirect handling.
// Rev    : 1.0
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic               clk,
    input  logic               rst,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    input  logic               redirect_valid,
    input  logic [31:0]        redirect_pc,
    input  logic               out_ready,
    output logic               out_valid,
    output logic [31:0]        PC,
    output logic [INSTR_W-1:0] instruction
);

    localparam int          CW        = $clog2(DEPTH) + 1;
    localparam logic [CW:0] c_depth   = (CW+1)'(DEPTH);
    localparam logic [CW:0] c_sum_one = {{CW{1'b0}}, 1'b1};
    localparam logic [CW-1:0] c_cnt_one = {{(CW-1){1'b0}}, 1'b1};

    logic [31:0]   r_pc;
    logic [CW-1:0] r_stale;

    logic [CW-1:0] w_alloc_cnt;
    logic [CW-1:0] w_unfilled;
    logic [CW:0]   w_occupancy;
    logic [CW:0]   w_outstanding;
    logic [CW:0]   w_stale_redirect;
    logic          w_grant;
    logic          w_drop;
    logic          w_fill;
    logic          w_pop;
    logic          w_head_valid;
    fetch_entry_t  w_head;
    logic          w_unused;

    assign w_occupancy   = {1'b0, w_alloc_cnt} + {1'b0, r_stale};
    assign w_outstanding = {1'b0, w_unfilled} + {1'b0, r_stale};

    assign imem_req  = !rst && !redirect_valid && (w_occupancy < c_depth);
    assign imem_addr = r_pc;

    assign w_grant = imem_req && imem_gnt;
    assign w_drop  = imem_rvalid && (r_stale != '0);
    assign w_fill  = imem_rvalid && (r_stale == '0) && (w_unfilled != '0) && !redirect_valid;
    assign w_pop   = w_head_valid && out_ready && !redirect_valid;

    // On redirect every unfilled request turns stale; a response arriving in
    // that same cycle retires one of them immediately.
    assign w_stale_redirect = (imem_rvalid && (w_outstanding != '0))
                            ? (w_outstanding - c_sum_one) : w_outstanding;

    assign w_unused = ^{redirect_pc[1:0], w_stale_redirect[CW]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_stale <= '0;
        end else if (redirect_valid) begin
            r_pc    <= {redirect_pc[31:2], 2'b00};
            r_stale <= w_stale_redirect[CW-1:0];
        end else begin
            if (w_grant) begin
                r_pc <= r_pc + 32'd4;
            end
            if (w_drop) begin
                r_stale <= r_stale - c_cnt_one;
            end
        end
    end

    fetch_buffer #(
        .DEPTH (DEPTH)
    ) u_buffer (
        .clk            (clk),
        .rst            (rst),
        .i_flush        (redirect_valid),
        .i_alloc        (w_grant),
        .i_alloc_pc     (r_pc),
        .i_fill         (w_fill),
        .i_fill_instr   (imem_rdata),
        .i_pop          (w_pop),
        .o_head_valid   (w_head_valid),
        .o_head         (w_head),
        .o_alloc_cnt    (w_alloc_cnt),
        .o_unfilled_cnt (w_unfilled)
    );

    assign out_valid   = w_head_valid;
    assign PC          = w_head_valid ? w_head.pc    : 32'h0;
    assign instruction = w_head_valid ? w_head.instr : NOP_INSTR;

`ifndef SYNTHESIS
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (rst)
        imem_rvalid |-> (w_outstanding != '0));
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// Module : tb_fetch_stage
// Desc   : Scoreboarded bench for fetch_stage with a variable-latency memory.
// Rev    : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_ready;
    logic        out_valid;
    logic [31:0] PC;
    logic [31:0] instruction;

    always #5 clk = ~clk;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_ready      (out_ready),
        .out_valid      (out_valid),
        .PC             (PC),
        .instruction    (instruction)
    );

    typedef struct { logic [31:0] pc; bit filled; } exp_t;
    typedef struct { logic [31:0] pc; int due; int epoch; } pend_t;
    typedef struct { logic [31:0] rpc; logic [31:0] exp_addr; } vec_t;

    exp_t        exp_q[$];
    pend_t       pend_q[$];
    logic [31:0] shown_q[$];

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    int          epoch  = 0;
    int          grants = 0;
    logic [31:0] ref_pc = RESET_PC;
    logic [31:0] s_addr;
    logic        s_req;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[17:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic chk_shown(input int idx, input logic [31:0] exp);
        if (idx < shown_q.size()) begin
            chk("shown_pc", shown_q[idx], exp);
        end else begin
            checks++;
            errors++;
            $display("FAIL shown_pc: entry %0d never presented, expected %h", idx, exp);
        end
    endtask

    // One clock cycle: drive at negedge, check and update the model, DUT
    // samples at the following posedge.
    task automatic cycle(input bit redir, input logic [31:0] rpc, input bit rdy,
                         input bit gnt, input int lat);
        int    occ;
        bit    exp_v;
        bit    exp_req;
        pend_t p;
        @(negedge clk);
        redirect_valid = redir;
        redirect_pc    = rpc;
        out_ready      = rdy;
        imem_gnt       = gnt;
        if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend_q[0].pc);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
        end
        #1;
        occ = exp_q.size();
        foreach (pend_q[i]) if (pend_q[i].epoch != epoch) occ++;
        exp_req = !redir && (occ < DEPTH);
        exp_v   = (exp_q.size() > 0) && exp_q[0].filled;
        s_addr  = imem_addr;
        s_req   = imem_req;

        chk("imem_req", 32'(imem_req), 32'(exp_req));
        chk("out_valid", 32'(out_valid), 32'(exp_v));
        if (imem_req && exp_req) chk("imem_addr", imem_addr, ref_pc);
        if (exp_v && out_valid) begin
            chk("PC", PC, exp_q[0].pc);
            chk("instruction", instruction, word_of(exp_q[0].pc));
        end
        if (out_valid === 1'b0) begin
            chk("idle_PC", PC, 32'h0);
            chk("idle_instr", instruction, NOP);
        end

        if (exp_v && rdy && !redir) begin
            shown_q.push_back(exp_q[0].pc);
            void'(exp_q.pop_front());
        end
        if (imem_rvalid) begin
            p = pend_q.pop_front();
            if (p.epoch == epoch) begin
                for (int i = 0; i < exp_q.size(); i++) begin
                    if (!exp_q[i].filled) begin
                        exp_q[i].filled = 1'b1;
                        break;
                    end
                end
            end
        end
        if (imem_req && gnt) begin
            exp_q.push_back('{pc: ref_pc, filled: 1'b0});
            pend_q.push_back('{pc: ref_pc, due: cyc + lat, epoch: epoch});
            ref_pc = ref_pc + 32'd4;
            grants++;
        end
        if (redir) begin
            exp_q.delete();
            epoch++;
            ref_pc = {rpc[31:2], 2'b00};
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        out_ready      = 1'b0;
        #1;
        chk("req_in_rst", 32'(imem_req), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_PC", PC, 32'h0);
        chk("rst_instr", instruction, NOP);
        chk("rst_addr", imem_addr, RESET_PC);
        chk("rst_req", 32'(imem_req), 32'h1);
        exp_q.delete();
        pend_q.delete();
        shown_q.delete();
        ref_pc = RESET_PC;
        grants = 0;
    endtask

    initial begin
        vec_t vecs[4];
        vecs[0] = '{rpc: 32'h0000_0203, exp_addr: 32'h0000_0200};
        vecs[1] = '{rpc: 32'h0000_0100, exp_addr: 32'h0000_0100};
        vecs[2] = '{rpc: 32'hFFFF_FFFE, exp_addr: 32'hFFFF_FFFC};
        vecs[3] = '{rpc: 32'h1000_0007, exp_addr: 32'h1000_0004};

        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        out_ready      = 1'b0;
        repeat (2) @(posedge clk);

        // Streaming with single-cycle memory.
        do_reset();
        repeat (20) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        chk_shown(0, 32'h0);
        chk_shown(1, 32'h4);
        chk_shown(2, 32'h8);
        chk_shown(3, 32'hC);

        // Decode stall: issue stops at DEPTH, head held.
        do_reset();
        repeat (10) cycle(1'b0, '0, 1'b0, 1'b1, 1);
        chk("stall_grants", 32'(grants), 32'(DEPTH));
        chk("stall_req", 32'(s_req), 32'h0);
        chk("stall_PC", PC, 32'h0);
        chk("stall_instr", instruction, word_of(32'h0));
        repeat (20) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        chk_shown(0, 32'h0);
        chk_shown(1, 32'h4);
        chk_shown(2, 32'h8);
        chk_shown(3, 32'hC);
        chk("resume_issue", 32'(grants > DEPTH), 32'h1);

        // Redirect with three slow fetches in flight.
        do_reset();
        repeat (3) cycle(1'b0, '0, 1'b1, 1'b1, 3);
        cycle(1'b1, 32'h0000_0100, 1'b1, 1'b0, 1);
        repeat (15) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        chk_shown(0, 32'h100);
        chk_shown(1, 32'h104);

        // Redirect target alignment table.
        for (int v = 0; v < 4; v++) begin
            cycle(1'b1, vecs[v].rpc, 1'b1, 1'b1, 2);
            cycle(1'b0, '0, 1'b1, 1'b1, 2);
            chk("redir_addr", s_addr, vecs[v].exp_addr);
        end

        // Back-to-back redirects: the second wins.
        cycle(1'b1, 32'h0000_0500, 1'b1, 1'b1, 2);
        cycle(1'b1, 32'h0000_0601, 1'b1, 1'b1, 2);
        cycle(1'b0, '0, 1'b1, 1'b1, 2);
        chk("b2b_addr", s_addr, 32'h0000_0600);

        // Random traffic against the scoreboard.
        for (int n = 0; n < 10000; n++) begin
            cycle($urandom_range(0, 99) < 3, $urandom, $urandom_range(0, 9) < 7,
                  $urandom_range(0, 9) < 6, int'($urandom_range(1, 5)));
        end
        for (int n = 0; n < 60; n++) cycle(1'b0, '0, 1'b1, 1'b0, 1);
        chk("drain_exp", 32'(exp_q.size()), 32'h0);
        chk("drain_pend", 32'(pend_q.size()), 32'h0);

        // Reset mid-stream with two requests outstanding.
        do_reset();
        repeat (2) cycle(1'b0, '0, 1'b1, 1'b1, 4);
        do_reset();
        repeat (10) cycle(1'b0, '0, 1'b1, 1'b1, 1);
        chk_shown(0, RESET_PC);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction fetch stage sitting directly upstream of decode_stage. It owns the architectural PC and issues in-order word fetches to a variable-latency instruction memory through a request/grant interface. Returned words are buffered with their PCs in a small ordered buffer. It presents PC/instruction pairs to decode with a valid/ready handshake. A redirect from execute flushes the buffer and drops in-flight responses.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
DEPTH, 4, buffer entries and maximum outstanding fetches (power of 2, 2..8)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request valid
imem_addr  output  32  fetch address, word aligned, equals pc_q
imem_gnt  input  1  memory accepts request this cycle when imem_req=1
imem_rvalid  input  1  read data valid; responses return in request order, earliest the cycle after grant
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  branch/jump taken: restart fetch at redirect_pc
redirect_pc  input  32  new fetch target; bits [1:0] ignored (treated as 0)
out_ready  input  1  decode can accept (low = stall)
out_valid  output  1  PC/instruction valid to decode
PC  output  32  PC of presented instruction
instruction  output  32  presented instruction word

Behaviour:
- Reset, applied on a clock edge while rst=1: pc_q=RESET_PC, buffer empty, alloc_cnt=0, stale_cnt=0. Outputs: imem_req=0, out_valid=0, PC=0, instruction=NOP (32'h0000_0013).
- rst has priority over all other inputs. Mid-operation reset discards the buffer and all in-flight state. The memory is reset together with this block, so no stale responses survive.
- Buffer: DEPTH-entry circular queue. Each entry holds pc, instr and a filled flag. Head/tail pointers wrap modulo DEPTH. alloc_cnt ranges 0..DEPTH.
- Issue: imem_req = !rst && !redirect_valid && (alloc_cnt + stale_cnt < DEPTH). imem_req is combinational from registered state and redirect_valid.
- On a cycle with imem_req && imem_gnt:
  - allocate the tail entry with pc=pc_q and filled=0;
  - next cycle pc_q = pc_q + 4, wrapping at 2^32.
- Response handling on imem_rvalid:
  - if stale_cnt>0, drop the data and decrement stale_cnt;
  - otherwise write imem_rdata into the oldest unfilled entry and set its filled flag.
  - Tracked by a fill pointer.
  - imem_rvalid with nothing outstanding is a protocol error; it is ignored and a simulation assertion fires.
- Output:
  - out_valid = head entry allocated and filled; PC and instruction are driven from the head entry.
  - When out_valid=0: PC=0, instruction=NOP.
  - Pop the head when out_valid && out_ready.
  - With out_ready=0, the head is held stable (PC and instruction unchanged).
- Latency: grant at cycle N, rvalid at N+k (k≥1). The entry becomes visible with out_valid=1 at N+k+1, registered.
- Redirect, on the redirect_valid cycle:
  - next pc_q = {redirect_pc[31:2],2'b00};
  - all buffer entries are flushed and alloc_cnt=0;
  - stale_cnt += number of allocated-but-unfilled entries, minus 1 if an rvalid in that same cycle would have filled one (that response is itself dropped);
  - no request is issued and no pop is taken that cycle, and out_valid is ignored by decode.
  - Fetch resumes the next cycle. New requests may issue while stale responses drain; stale responses are dropped before new ones fill.
- Simultaneous events:
  - grant + rvalid + pop in one cycle is legal; all three counters/pointers update consistently.
  - When the buffer is full (alloc_cnt=DEPTH), a pop in the same cycle does not enable issue until the next cycle, because issue uses registered counts.
  - Back-to-back redirects: the last one wins, and stale_cnt accumulates correctly.

Decomposition:
- Shared package fetch_pkg: NOP_INSTR=32'h0000_0013, INSTR_W=32, and a fetch entry typedef {pc, instr, filled}.
- One natural sub-module, fetch_buffer: the circular queue with alloc/fill/pop/flush ports and the alloc_cnt output.
- fetch_stage keeps pc_q, the issue logic and stale_cnt.

Test Plan:
- Reset, then memory with grant always 1 and 1-cycle latency, out_ready=1 → one instruction per cycle after fill; PCs 0x0,0x4,0x8,0xC with the matching words.
- out_ready=0 for 10 cycles → exactly DEPTH=4 requests issued, then imem_req=0. PC holds 0x0 and instruction holds its word. Releasing out_ready drains 0x0..0xC in order, and issue resumes.
- 3 fetches in flight with 3-cycle latency, then redirect_pc=0x100 → the 3 old responses are dropped. The next presented PCs are 0x100,0x104, with no 0x0–0x8 instruction visible.
- redirect_pc=0x203 → fetch address is 0x200.
- Random grant/latency/out_ready for 10k cycles against a reference PC model → in-order, no loss or duplication, and alloc_cnt+stale_cnt never exceeds 4.
- Assert rst for one cycle mid-stream with 2 requests outstanding → next cycle out_valid=0, instruction=0x00000013 and imem_req=0 during rst. The first request after reset has address RESET_PC.
